srlatch_driver: RTL and testbench
=================================

SRLATCH_DRIVER -- requirements
Module: srlatch_driver

Interface
REQ-001 Parameter SETUP_CYC, default 1: cycles S/R are held stable with C=0 before the enable pulse; legal range 1..255.
REQ-002 Parameter PULSE_CYC, default 2: cycles C is held high; legal range 1..255.
REQ-003 Parameter HOLD_CYC, default 1: cycles S/R are held stable with C=0 after the enable pulse; legal range 1..255.
REQ-004 clk  input  1  single clock; all logic on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 cmd_valid  input  1  command request.
REQ-007 cmd_op  input  1  1 = set latch, 0 = reset latch; sampled on accept.
REQ-008 cmd_ready  output  1  driver can accept a command.
REQ-009 lat_S  output  1  latch S drive.
REQ-010 lat_R  output  1  latch R drive.
REQ-011 lat_C  output  1  latch enable drive.
REQ-012 lat_Q  input  1  latch Q feedback.
REQ-013 busy  output  1  command in progress.
REQ-014 done  output  1  one-cycle pulse, command complete.
REQ-015 err  output  1  one-cycle pulse coincident with done when Q readback mismatches cmd_op.

Function
REQ-016 The block SHALL implement FSM states IDLE, SETUP, PULSE, HOLD, CHECK.
REQ-017 Accept SHALL occur on a rising edge with cmd_valid=1 and cmd_ready=1; cmd_op is latched internally; the FSM moves IDLE->SETUP.
REQ-018 cmd_ready SHALL be 1 exactly when the state is IDLE; busy SHALL be its complement.
REQ-019 SETUP: lat_S=op, lat_R=~op, lat_C=0 for SETUP_CYC cycles, then the FSM moves to PULSE.
REQ-020 PULSE: lat_S/lat_R unchanged, lat_C=1 for PULSE_CYC cycles, then the FSM moves to HOLD.
REQ-021 HOLD: lat_S/lat_R unchanged, lat_C=0 for HOLD_CYC cycles, then the FSM moves to CHECK.
REQ-022 CHECK: lat_S=lat_R=lat_C=0 for one cycle; lat_Q is registered at the end of that cycle; the FSM moves to IDLE.
REQ-023 On the first IDLE cycle after CHECK: done=1; err=1 iff the sampled Q != latched op; both are 0 otherwise.
REQ-024 Latency from the accept edge to the done cycle SHALL be SETUP_CYC+PULSE_CYC+HOLD_CYC+2 cycles (6 with defaults).
REQ-025 A command accepted in the same cycle done is high SHALL be honoured (back-to-back, no idle gap required).
REQ-026 lat_S and lat_R SHALL never be 1 simultaneously; lat_C SHALL be 1 only in PULSE; lat_S/lat_R SHALL never change while lat_C=1.
REQ-027 All lat_* outputs, done and err SHALL be registered (glitch-free).
REQ-028 cmd_valid/cmd_op SHALL be ignored outside IDLE.
REQ-029 Phase length SHALL come from an 8-bit down-counter loaded with N-1 on phase entry; the phase ends when the count reaches 0, so a parameter value of 1 yields exactly one cycle.

Reset
REQ-030 rst_n=0 SHALL asynchronously force state IDLE, lat_S=lat_R=lat_C=0, done=err=0, busy=0, counter=0 and latched op=0; cmd_ready reads 1.
REQ-031 Reset mid-command SHALL abort the command with no done/err pulse; the first command after reset release SHALL start cleanly.

Structure
REQ-032 State encodings and op codes (OP_SET=1, OP_RESET=0) SHALL reside in the shared package srlatch_drv_pkg.
REQ-033 The phase counter SHALL be the sub-module phase_counter (load, load value, decrement, zero flag, same clk/rst_n).

Verification
REQ-034 Defaults; cmd_op=1 accepted at cycle 0; model latch sets Q=1 -> S=1 cycles 1-4, C=1 cycles 2-3, CHECK cycle 5, done=1/err=0 at cycle 6.
REQ-035 cmd_op=0 with latch model returning Q=1 (stuck) -> done=1 and err=1 at cycle 6.
REQ-036 cmd_valid held high with ops 1,0,1 -> three accepts 6 cycles apart, Q sequence 1,0,1, three done pulses, no err.
REQ-037 rst_n=0 asserted during PULSE -> lat_C falls asynchronously, no done; a subsequent set completes normally.
REQ-038 SETUP_CYC=3, PULSE_CYC=1, HOLD_CYC=4 -> done exactly 10 cycles after accept; assertion checks that S&R is never 1 and S/R never change while C=1 throughout all tests.

Source files
------------

// File: rtl/srlatch_driver_pkg.sv
// Shared types for the SR-latch driver: FSM state encoding, op codes, phase counter helpers.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package srlatch_drv_pkg;

  // Driver sequencing states; one command walks IDLE->SETUP->PULSE->HOLD->CHECK->IDLE.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_PULSE = 3'd2,
    ST_HOLD  = 3'd3,
    ST_CHECK = 3'd4
  } state_t;

  localparam logic OP_SET   = 1'b1;
  localparam logic OP_RESET = 1'b0;

  localparam int CNT_W = 8;

  // A phase of N cycles loads N-1 so that the zero flag marks its last cycle.
  function automatic logic [CNT_W-1:0] phase_load(input int n);
    return CNT_W'(n - 1);
  endfunction

endpackage

// File: rtl/srlatch_driver_if.sv
// Command handshake plus latch drive/feedback bundle for the SR-latch driver.
// Latency: n/a (wiring only).
// Backpressure: cmd_ready from the driver gates cmd_valid from the requester.
interface srlatch_driver_if;

  logic cmd_valid;
  logic cmd_op;
  logic cmd_ready;
  logic lat_S;
  logic lat_R;
  logic lat_C;
  logic lat_Q;
  logic busy;
  logic done;
  logic err;

  // Driver side: accepts commands, drives the latch, reads Q back.
  modport master (
    input  cmd_valid, cmd_op, lat_Q,
    output cmd_ready, lat_S, lat_R, lat_C, busy, done, err
  );

  // Requester/latch side: issues commands and returns latch Q.
  modport slave (
    output cmd_valid, cmd_op, lat_Q,
    input  cmd_ready, lat_S, lat_R, lat_C, busy, done, err
  );

endinterface

// File: rtl/srlatch_driver_phase_counter.sv
// Phase-length down-counter: load N-1 on phase entry, count down, flag zero.
// Latency: load/decrement visible one cycle later; zero flag is combinational from the count.
// Backpressure: none; decrement saturates at zero.
module phase_counter
  import srlatch_drv_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  input  logic             i_dec,
  output logic             o_zero
);

  logic [CNT_W-1:0] r_cnt;

  // Load has priority so a phase boundary restarts the count on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_dec && (r_cnt != '0)) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/srlatch_driver.sv
// Sequences S/R setup, C enable pulse, hold and Q readback for one latch write per command.
// Latency: SETUP_CYC+PULSE_CYC+HOLD_CYC+2 cycles from accept edge to the done cycle.
// Backpressure: cmd_ready only in IDLE; a new command may be accepted in the done cycle.
module srlatch_driver
  import srlatch_drv_pkg::*;
#(
  parameter int SETUP_CYC = 1,  // 1..255
  parameter int PULSE_CYC = 2,  // 1..255
  parameter int HOLD_CYC  = 1   // 1..255
)(
  input  logic             clk,
  input  logic             rst_n,
  srlatch_driver_if.master bus
);

  localparam logic [CNT_W-1:0] SETUP_LD = phase_load(SETUP_CYC);
  localparam logic [CNT_W-1:0] PULSE_LD = phase_load(PULSE_CYC);
  localparam logic [CNT_W-1:0] HOLD_LD  = phase_load(HOLD_CYC);

  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_op;
  logic             w_op_nxt;
  logic             r_lat_S;
  logic             r_lat_R;
  logic             r_lat_C;
  logic             r_done;
  logic             r_err;
  logic             w_lat_S_nxt;
  logic             w_lat_R_nxt;
  logic             w_lat_C_nxt;
  logic             w_cnt_load;
  logic [CNT_W-1:0] w_cnt_load_val;
  logic             w_cnt_dec;
  logic             w_cnt_zero;
  logic             w_ready;
  logic             w_drive;

  phase_counter u_phase_counter (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_load     (w_cnt_load),
    .i_load_val (w_cnt_load_val),
    .i_dec      (w_cnt_dec),
    .o_zero     (w_cnt_zero)
  );

  assign w_ready = (r_state == ST_IDLE);

  // Next-state, counter control and next values of the registered latch drives.
  always_comb begin
    w_state_nxt    = r_state;
    w_op_nxt       = r_op;
    w_cnt_load     = 1'b0;
    w_cnt_load_val = '0;
    w_cnt_dec      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (bus.cmd_valid) begin
          w_state_nxt    = ST_SETUP;
          w_op_nxt       = bus.cmd_op;
          w_cnt_load     = 1'b1;
          w_cnt_load_val = SETUP_LD;
        end
      end
      ST_SETUP: begin
        if (w_cnt_zero) begin
          w_state_nxt    = ST_PULSE;
          w_cnt_load     = 1'b1;
          w_cnt_load_val = PULSE_LD;
        end else begin
          w_cnt_dec = 1'b1;
        end
      end
      ST_PULSE: begin
        if (w_cnt_zero) begin
          w_state_nxt    = ST_HOLD;
          w_cnt_load     = 1'b1;
          w_cnt_load_val = HOLD_LD;
        end else begin
          w_cnt_dec = 1'b1;
        end
      end
      ST_HOLD: begin
        if (w_cnt_zero) begin
          w_state_nxt = ST_CHECK;
        end else begin
          w_cnt_dec = 1'b1;
        end
      end
      ST_CHECK: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase

    // S/R are driven from SETUP through HOLD from the latched op, so they cannot
    // move while C is high and are never both asserted.
    w_drive     = (w_state_nxt == ST_SETUP) || (w_state_nxt == ST_PULSE) ||
                  (w_state_nxt == ST_HOLD);
    w_lat_S_nxt = w_drive && (w_op_nxt == OP_SET);
    w_lat_R_nxt = w_drive && (w_op_nxt == OP_RESET);
    w_lat_C_nxt = (w_state_nxt == ST_PULSE);
  end

  // State, latched op and all glitch-free registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_op    <= OP_RESET;
      r_lat_S <= 1'b0;
      r_lat_R <= 1'b0;
      r_lat_C <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_op    <= w_op_nxt;
      r_lat_S <= w_lat_S_nxt;
      r_lat_R <= w_lat_R_nxt;
      r_lat_C <= w_lat_C_nxt;
      // Q is sampled at the end of CHECK; the result shows up in the first IDLE cycle.
      r_done  <= (r_state == ST_CHECK);
      r_err   <= (r_state == ST_CHECK) && (bus.lat_Q != r_op);
    end
  end

  assign bus.cmd_ready = w_ready;
  assign bus.busy      = ~w_ready;
  assign bus.lat_S     = r_lat_S;
  assign bus.lat_R     = r_lat_R;
  assign bus.lat_C     = r_lat_C;
  assign bus.done      = r_done;
  assign bus.err       = r_err;

endmodule

// File: tb/tb_srlatch_driver.sv
// Directed bench for srlatch_driver: default timing, stuck Q, back-to-back, reset abort, long phases.
// Latency: checks accept-to-done of 6 (defaults) and 10 (3/1/4).
// Backpressure: exercises cmd_valid held high across commands.
module tb_srlatch_driver;
  import srlatch_drv_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  srlatch_driver_if if1 ();
  srlatch_driver_if if2 ();

  srlatch_driver dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if1.master)
  );

  srlatch_driver #(.SETUP_CYC(3), .PULSE_CYC(1), .HOLD_CYC(4)) dut2 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if2.master)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s observed=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // Latch models: Q follows S/R while C is high; stuck1 forces dut1's Q to 1.
  logic q1 = 1'b0;
  logic q2 = 1'b0;
  logic stuck1 = 1'b0;
  always @(posedge clk) begin
    if (if1.lat_C) begin
      if (if1.lat_S) q1 <= 1'b1;
      else if (if1.lat_R) q1 <= 1'b0;
    end
    if (if2.lat_C) begin
      if (if2.lat_S) q2 <= 1'b1;
      else if (if2.lat_R) q2 <= 1'b0;
    end
  end
  assign if1.lat_Q = stuck1 ? 1'b1 : q1;
  assign if2.lat_Q = q2;

  // Continuous safety monitor: S&R exclusion, S/R frozen while C high, C only while busy.
  int viol = 0;
  int ndone1 = 0;
  logic pS1 = 1'b0, pR1 = 1'b0, pS2 = 1'b0, pR2 = 1'b0;
  always @(negedge clk) begin
    if (rst_n) begin
      if (if1.lat_S && if1.lat_R) viol++;
      if (if2.lat_S && if2.lat_R) viol++;
      if (if1.lat_C && ((if1.lat_S != pS1) || (if1.lat_R != pR1))) viol++;
      if (if2.lat_C && ((if2.lat_S != pS2) || (if2.lat_R != pR2))) viol++;
      if (if1.lat_C && if1.cmd_ready) viol++;
      if (if2.lat_C && if2.cmd_ready) viol++;
      if (if1.done) ndone1++;
    end
    pS1 = if1.lat_S; pR1 = if1.lat_R;
    pS2 = if2.lat_S; pR2 = if2.lat_R;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0] ops;
    int d0;
    ops = 3'b101;
    if1.cmd_valid = 1'b0; if1.cmd_op = 1'b0;
    if2.cmd_valid = 1'b0; if2.cmd_op = 1'b0;

    // Reset state
    @(negedge clk);
    check("rst_ready", int'(if1.cmd_ready), 1);
    check("rst_busy",  int'(if1.busy), 0);
    check("rst_SRC",   int'({if1.lat_S, if1.lat_R, if1.lat_C}), 0);
    check("rst_done_err", int'({if1.done, if1.err}), 0);
    step();
    rst_n = 1'b1;
    step();

    // Test 1: set with defaults, cycle-accurate waveform
    if1.cmd_valid = 1'b1; if1.cmd_op = 1'b1;
    step();
    if1.cmd_valid = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      check($sformatf("t1_S_c%0d", c),    int'(if1.lat_S), int'(c <= 4));
      check($sformatf("t1_R_c%0d", c),    int'(if1.lat_R), 0);
      check($sformatf("t1_C_c%0d", c),    int'(if1.lat_C), int'(c == 2 || c == 3));
      check($sformatf("t1_busy_c%0d", c), int'(if1.busy),  int'(c <= 5));
      check($sformatf("t1_done_c%0d", c), int'(if1.done),  int'(c == 6));
      check($sformatf("t1_err_c%0d", c),  int'(if1.err),   0);
      if (c < 6) step();
    end
    step();
    @(negedge clk);
    check("t1_done_single", int'(if1.done), 0);

    // Test 2: reset command against a Q stuck at 1
    stuck1 = 1'b1;
    if1.cmd_valid = 1'b1; if1.cmd_op = 1'b0;
    step();
    if1.cmd_valid = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      check($sformatf("t2_R_c%0d", c),    int'(if1.lat_R), int'(c <= 4));
      check($sformatf("t2_S_c%0d", c),    int'(if1.lat_S), 0);
      check($sformatf("t2_done_c%0d", c), int'(if1.done),  int'(c == 6));
      check($sformatf("t2_err_c%0d", c),  int'(if1.err),   int'(c == 6));
      if (c < 6) step();
    end
    step();
    stuck1 = 1'b0;

    // Test 3: cmd_valid held high, ops 1,0,1 back-to-back; cmd_op wiggled mid-command
    d0 = ndone1;
    if1.cmd_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      if1.cmd_op = ops[k];
      step();
      if1.cmd_op = ~ops[k];
      for (int c = 1; c <= 5; c++) begin
        @(negedge clk);
        if (c == 1) check($sformatf("t3_busy_k%0d", k), int'(if1.busy), 1);
        if (c == 3) begin
          check($sformatf("t3_C_k%0d", k), int'(if1.lat_C), 1);
          check($sformatf("t3_S_k%0d", k), int'(if1.lat_S), int'(ops[k]));
          check($sformatf("t3_R_k%0d", k), int'(if1.lat_R), int'(!ops[k]));
        end
        step();
      end
      @(negedge clk);
      check($sformatf("t3_done_k%0d", k),  int'(if1.done), 1);
      check($sformatf("t3_err_k%0d", k),   int'(if1.err), 0);
      check($sformatf("t3_ready_k%0d", k), int'(if1.cmd_ready), 1);
      check($sformatf("t3_Q_k%0d", k),     int'(if1.lat_Q), int'(ops[k]));
    end
    if1.cmd_valid = 1'b0;
    step();
    @(negedge clk);
    check("t3_idle_after", int'(if1.busy), 0);
    check("t3_done_count", ndone1 - d0, 3);

    // Test 4: reset asserted during PULSE aborts the command
    step();
    if1.cmd_valid = 1'b1; if1.cmd_op = 1'b1;
    step();
    if1.cmd_valid = 1'b0;
    step();
    @(negedge clk);
    check("t4_C_before", int'(if1.lat_C), 1);
    #2 rst_n = 1'b0;
    #1;
    check("t4_C_async",  int'(if1.lat_C), 0);
    check("t4_S_async",  int'(if1.lat_S), 0);
    check("t4_ready",    int'(if1.cmd_ready), 1);
    check("t4_busy",     int'(if1.busy), 0);
    d0 = ndone1;
    step();
    rst_n = 1'b1;
    repeat (8) step();
    @(negedge clk);
    check("t4_no_done", ndone1 - d0, 0);
    step();
    if1.cmd_valid = 1'b1; if1.cmd_op = 1'b1;
    step();
    if1.cmd_valid = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      if (c == 1) check("t4b_S_c1", int'(if1.lat_S), 1);
      check($sformatf("t4b_done_c%0d", c), int'(if1.done), int'(c == 6));
      if (c == 6) check("t4b_err", int'(if1.err), 0);
      if (c < 6) step();
    end
    step();

    // Test 5: SETUP=3, PULSE=1, HOLD=4 -> done 10 cycles after accept
    if2.cmd_valid = 1'b1; if2.cmd_op = 1'b1;
    step();
    if2.cmd_valid = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      check($sformatf("t5_C_c%0d", c),    int'(if2.lat_C), int'(c == 4));
      check($sformatf("t5_S_c%0d", c),    int'(if2.lat_S), int'(c <= 8));
      check($sformatf("t5_busy_c%0d", c), int'(if2.busy),  int'(c <= 9));
      check($sformatf("t5_done_c%0d", c), int'(if2.done),  int'(c == 10));
      if (c == 10) check("t5_err", int'(if2.err), 0);
      if (c < 10) step();
    end
    step();

    check("sr_safety_violations", viol, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
